time_adjust_ctrl: RTL and testbench

- Front-end controller for the clock's time-setting interface. It is the producer of the adjust/select signals that the 7-segment display block consumes.
- Debounces the four DE2 push-buttons and runs a RUN/ADJUST mode state machine.
- Outputs: the display-mode flag, the 4-bit digit-select index, and single-cycle increment/decrement strobes to the time-register block.

---
 rtl/time_pkg.sv | 25 ++
 rtl/key_debounce.sv | 70 +++++++
 rtl/time_adjust_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_time_adjust_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/time_pkg.sv
// time_pkg: shared definitions for the time-setting front end.
//   - state_e      : RUN / ADJUST mode encoding
//   - KEY_*        : index of each push-button within the 4-bit KEY bus
//   - SELECT_*     : digit-select limits (0..7 time digits, 8..15 date digits)
//   - next_select(): digit index advance with wrap 15 -> 0
package time_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_ADJUST = 1'b1
  } state_e;

  localparam int KEY_MODE = 0;
  localparam int KEY_NEXT = 1;
  localparam int KEY_INC  = 2;
  localparam int KEY_DEC  = 3;

  localparam logic [3:0] SELECT_TIME_LAST = 4'd7;
  localparam logic [3:0] SELECT_LAST      = 4'd15;

  function automatic logic [3:0] next_select(input logic [3:0] sel);
    return (sel == SELECT_LAST) ? 4'd0 : sel + 4'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: one push-button input path.
//   Two-flop synchroniser, stable-time debounce counter, press-edge strobe.
//   Ports:
//     clk_i    in  clock
//     rst_ni   in  asynchronous active-low reset
//     key_ni   in  raw active-low key, asynchronous to clk_i
//     press_o  out one-cycle strobe on the debounced 1->0 edge
//     level_o  out debounced level (1 = released); present only when
//                  TIME_ADJUST_AUTO_REPEAT_EN is defined
//   The debounced level falls 2 + DEBOUNCE_CYCLES cycles after a clean raw
//   edge; press_o is high in the cycle right after that clock edge.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic press_o
`ifdef TIME_ADJUST_AUTO_REPEAT_EN
  ,
  output logic level_o
`endif
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synced input disagrees with the
  // debounced level, so any bounce back to the old level restarts it.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    press_d = level_q & ~level_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_ni;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;
`ifdef TIME_ADJUST_AUTO_REPEAT_EN
  assign level_o = level_q;
`endif

endmodule

// File: rtl/time_adjust_ctrl.sv
// time_adjust_ctrl: time-setting front end for the clock display.
//   Debounces KEY[3:0] and runs the RUN/ADJUST mode machine.
//   Ports:
//     CLOCK_50   in  system clock
//     rst_n      in  asynchronous active-low reset
//     KEY[3:0]   in  raw active-low buttons: 0 mode, 1 next, 2 inc, 3 dec
//     adjust     out 1 = running display, 0 = adjust mode (also the mode state)
//     select     out digit index being adjusted (0..15)
//     hold       out 1 = time counters frozen (throughout ADJUST)
//     inc_pulse  out one-cycle increment strobe for the selected digit
//     dec_pulse  out one-cycle decrement strobe for the selected digit
//   Build option: TIME_ADJUST_AUTO_REPEAT_EN adds auto-repeat of inc/dec
//   while the key stays held in ADJUST.
//   Press priority within one cycle: mode > next > inc > dec.
module time_adjust_ctrl
  import time_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TIMEOUT_CYCLES  = 500_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic [3:0] KEY,
  output logic       adjust,
  output logic [3:0] select,
  output logic       hold,
  output logic       inc_pulse,
  output logic       dec_pulse
);

  if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 2 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("time_adjust_ctrl: cycle-count parameters out of range");
  end

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [3:0] key_press;
`ifdef TIME_ADJUST_AUTO_REPEAT_EN
  logic [3:0] key_level;
`endif

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk_i   (CLOCK_50),
      .rst_ni  (rst_n),
      .key_ni  (KEY[i]),
`ifdef TIME_ADJUST_AUTO_REPEAT_EN
      .level_o (key_level[i]),
`endif
      .press_o (key_press[i])
    );
  end

  logic ev_inc, ev_dec;

`ifdef TIME_ADJUST_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d, rep_last;
  logic          rep_armed_q, rep_armed_d;
  logic          rep_period_q, rep_period_d;
  logic          rep_fire;
  logic          inc_held, dec_held;
  state_e        state_q;

  assign inc_held = ~key_level[KEY_INC];
  assign dec_held = ~key_level[KEY_DEC];
  assign rep_last = rep_period_q ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);

  // Armed by an inc/dec press strobe seen in ADJUST; the first repeat waits
  // REPEAT_DELAY cycles, later ones REPEAT_PERIOD cycles.
  always_comb begin
    rep_cnt_d    = rep_cnt_q;
    rep_armed_d  = rep_armed_q;
    rep_period_d = rep_period_q;
    rep_fire     = 1'b0;
    if (state_q != ST_ADJUST || !(inc_held || dec_held)) begin
      rep_cnt_d    = '0;
      rep_armed_d  = 1'b0;
      rep_period_d = 1'b0;
    end else if (key_press[KEY_INC] || key_press[KEY_DEC]) begin
      rep_cnt_d    = '0;
      rep_armed_d  = 1'b1;
      rep_period_d = 1'b0;
    end else if (rep_armed_q) begin
      if (rep_cnt_q == rep_last) begin
        rep_fire     = 1'b1;
        rep_cnt_d    = '0;
        rep_period_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q    <= '0;
      rep_armed_q  <= 1'b0;
      rep_period_q <= 1'b0;
    end else begin
      rep_cnt_q    <= rep_cnt_d;
      rep_armed_q  <= rep_armed_d;
      rep_period_q <= rep_period_d;
    end
  end

  assign ev_inc = key_press[KEY_INC] | (rep_fire & inc_held);
  assign ev_dec = key_press[KEY_DEC] | (rep_fire & ~inc_held & dec_held);
`else
  state_e state_q;

  assign ev_inc = key_press[KEY_INC];
  assign ev_dec = key_press[KEY_DEC];
`endif

  state_e        state_d;
  logic [3:0]    select_q, select_d;
  logic          inc_q, inc_d;
  logic          dec_q, dec_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // Priority chain: only the highest-priority event acts, and any acted
  // press leaves the timeout counter at zero even if it was about to expire.
  always_comb begin
    state_d  = state_q;
    select_d = select_q;
    inc_d    = 1'b0;
    dec_d    = 1'b0;
    to_cnt_d = to_cnt_q;
    case (state_q)
      ST_RUN: begin
        to_cnt_d = '0;
        if (key_press[KEY_MODE]) begin
          state_d  = ST_ADJUST;
          select_d = 4'd0;
        end
      end
      ST_ADJUST: begin
        to_cnt_d = '0;
        if (key_press[KEY_MODE]) begin
          state_d = ST_RUN;
        end else if (key_press[KEY_NEXT]) begin
          select_d = next_select(select_q);
        end else if (ev_inc) begin
          inc_d = 1'b1;
        end else if (ev_dec) begin
          dec_d = 1'b1;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = ST_RUN;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      select_q <= 4'd0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      select_q <= select_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  assign adjust    = (state_q == ST_RUN);
  assign hold      = (state_q == ST_ADJUST);
  assign select    = select_q;
  assign inc_pulse = inc_q;
  assign dec_pulse = dec_q;

endmodule

// File: tb/tb_time_adjust_ctrl.sv
// tb_time_adjust_ctrl: directed bench for time_adjust_ctrl with small cycle
// parameters. Expected output events {adjust, hold, select, inc, dec} are
// queued as keys are driven and popped by a negedge monitor whenever the
// DUT's outputs change or a strobe is high.
module tb_time_adjust_ctrl;

  localparam int DB = 4;
  localparam int TO = 64;
  localparam int RD = 16;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key = 4'hF;
  logic       adjust, hold, inc_pulse, dec_pulse;
  logic [3:0] select;

  always #10 clk = ~clk;

  time_adjust_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TO),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .CLOCK_50  (clk),
    .rst_n     (rst_n),
    .KEY       (key),
    .adjust    (adjust),
    .select    (select),
    .hold      (hold),
    .inc_pulse (inc_pulse),
    .dec_pulse (dec_pulse)
  );

  logic [7:0] exp_q[$];
  int         strobe_cyc_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         last_evt_cyc = 0;
  int         drv_cyc = 0;
  logic [5:0] prev = 6'b10_0000;
  logic       m_adj = 1'b1;
  logic [3:0] m_sel = 4'd0;

  // Monitor: every output event must match the head of the expected queue.
  always @(negedge clk) begin
    logic [7:0] obs;
    logic [7:0] exp_v;
    cyc++;
    obs = {adjust, hold, select, inc_pulse, dec_pulse};
    if (rst_n && ((obs[7:2] != prev) || inc_pulse || dec_pulse)) begin
      last_evt_cyc = cyc;
      if (inc_pulse || dec_pulse) strobe_cyc_q.push_back(cyc);
      vectors++;
      assert (exp_q.size() > 0) else begin
        miscompares++;
        $error("FAIL unexpected_event got=%h required=none", obs);
      end
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        vectors++;
        assert (obs === exp_v) else begin
          miscompares++;
          $error("FAIL event got=%h required=%h", obs, exp_v);
        end
      end
    end
    prev = obs[7:2];
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    vectors++;
    assert (got === exp_v) else begin
      miscompares++;
      $error("FAIL %s got=%0h required=%0h", tag, got, exp_v);
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    check(tag, exp_q.size(), 0);
  endtask

  task automatic push_state();
    exp_q.push_back({m_adj, ~m_adj, m_sel, 2'b00});
  endtask

  task automatic hold_keys(input logic [3:0] mask, input int n);
    @(posedge clk);
    #1;
    key = key & ~mask;
    drv_cyc = cyc;
    repeat (n) @(posedge clk);
    #1;
    key = key | mask;
    repeat ($urandom_range(8, 14)) @(posedge clk);
  endtask

  // Pushes the expected effect of a press (priority mode > next > inc > dec)
  // and then drives the keys.
  task automatic do_press(input logic [3:0] mask, input int n);
    if (mask[0]) begin
      if (m_adj) begin
        m_adj = 1'b0;
        m_sel = 4'd0;
      end else begin
        m_adj = 1'b1;
      end
      push_state();
    end else if (!m_adj) begin
      if (mask[1]) begin
        m_sel = m_sel + 4'd1;
        push_state();
      end else if (mask[2]) begin
        exp_q.push_back({m_adj, ~m_adj, m_sel, 2'b10});
      end else if (mask[3]) begin
        exp_q.push_back({m_adj, ~m_adj, m_sel, 2'b01});
      end
    end
    hold_keys(mask, n);
  endtask

  initial begin
    int t0;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_adjust", adjust, 1);
    check("rst_hold", hold, 0);
    check("rst_select", select, 0);
    check("rst_strobes", {inc_pulse, dec_pulse}, 0);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    check("idle_after_reset", {adjust, hold, select, inc_pulse, dec_pulse}, 8'h80);

    // Mode press with bounce at its start
    m_adj = 1'b0;
    m_sel = 4'd0;
    push_state();
    @(posedge clk); #1 key[0] = 1'b0;
    @(posedge clk); #1 key[0] = 1'b1;
    @(posedge clk); #1 key[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1 key[0] = 1'b1;
    repeat (12) @(posedge clk);
    wait_drain("enter_adjust", 50);
    check("adj_adjust", adjust, 0);
    check("adj_hold", hold, 1);

    // Next presses; first one also checks press-to-output latency
    do_press(4'b0010, 8);
    wait_drain("next_first", 50);
    check("press_latency", last_evt_cyc - drv_cyc, 2 + DB + 2);
    for (int i = 0; i < 3; i++) do_press(4'b0010, 8);
    wait_drain("next_4", 50);
    check("select_4", select, 4);

    // Full lap of 16 next presses crosses the 15 -> 0 wrap
    for (int i = 0; i < 16; i++) do_press(4'b0010, 8);
    wait_drain("next_wrap", 50);
    check("select_after_lap", select, 4);

    do_press(4'b0100, 8);
    do_press(4'b1000, 8);
    wait_drain("inc_dec", 50);

    // Simultaneous presses
    do_press(4'b1100, 8);
    wait_drain("inc_dec_same_cycle", 50);
    do_press(4'b0101, 8);
    wait_drain("mode_inc_same_cycle", 50);
    check("mode_inc_adjust", adjust, 1);

    // Timeout
    do_press(4'b0001, 8);
    wait_drain("enter_adjust_2", 50);
    t0 = last_evt_cyc;
    m_adj = 1'b1;
    push_state();
    wait_drain("timeout", 200);
    check("timeout_latency", last_evt_cyc - t0, TO);
    check("timeout_hold", hold, 0);
    do_press(4'b0100, 8);
    repeat (20) @(posedge clk);
    wait_drain("inc_in_run", 10);

    // Held inc key, then timeout from the last strobe
    do_press(4'b0001, 8);
    wait_drain("enter_adjust_3", 50);
    strobe_cyc_q.delete();
    exp_q.push_back({1'b0, 1'b1, m_sel, 2'b10});
`ifdef TIME_ADJUST_AUTO_REPEAT_EN
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 1'b1, m_sel, 2'b10});
`endif
    m_adj = 1'b1;
    push_state();
    hold_keys(4'b0100, 44);
    wait_drain("held_inc", 200);
`ifdef TIME_ADJUST_AUTO_REPEAT_EN
    check("repeat_count", strobe_cyc_q.size(), 5);
    if (strobe_cyc_q.size() == 5) begin
      check("repeat_first", strobe_cyc_q[1] - strobe_cyc_q[0], RD);
      for (int i = 2; i < 5; i++) check("repeat_period", strobe_cyc_q[i] - strobe_cyc_q[i-1], RP);
    end
`else
    check("held_strobe_count", strobe_cyc_q.size(), 1);
`endif

    // Reset in the middle of ADJUST with an inc strobe on its way
    do_press(4'b0001, 8);
    do_press(4'b0010, 8);
    wait_drain("pre_reset", 50);
    check("pre_reset_select", select, 1);
    @(posedge clk); #1 key[2] = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_adjust", adjust, 1);
    check("midrst_hold", hold, 0);
    check("midrst_select", select, 0);
    check("midrst_strobes", {inc_pulse, dec_pulse}, 0);
    key = 4'hF;
    m_adj = 1'b1;
    m_sel = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    wait_drain("after_midrst", 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
